// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared phase encoding and lamp indices for the traffic controller and the
// scan display block that decodes n1/n2.
package traffic_phase_ctrl_pkg;

   typedef enum logic [2:0] {
      PH_MG    = 3'd0,
      PH_MY    = 3'd1,
      PH_SG    = 3'd2,
      PH_SY    = 3'd3,
      PH_FLASH = 3'd4,
      PH_OFF   = 3'd5
   } phase_e;

   localparam logic [2:0] LAMP_MAIN_G = 3'd0;
   localparam logic [2:0] LAMP_MAIN_Y = 3'd1;
   localparam logic [2:0] LAMP_SUB_G  = 3'd2;
   localparam logic [2:0] LAMP_SUB_Y  = 3'd3;
   localparam logic [2:0] LAMP_NONE   = 3'd5;

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks; clr restarts the
// count from zero and suppresses the tick.
module tick_gen #(
   parameter int TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: state flops use non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light phase controller: four-phase timed cycle with
// flashing-yellow night mode and blanked off mode, feeding the scan display.
module traffic_phase_ctrl
   import traffic_phase_ctrl_pkg::*;
#(
   parameter int TICK_DIV    = 100000000,
   parameter int MAIN_GREEN  = 30,
   parameter int MAIN_YELLOW = 3,
   parameter int SUB_GREEN   = 20,
   parameter int SUB_YELLOW  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       night,
   input  logic       off,
   output logic [6:0] main_rest_time,
   output logic [6:0] sub_rest_time,
   output logic       dis,
   output logic       non,
   output logic [2:0] n1,
   output logic [2:0] n2
);

   if (MAIN_GREEN + MAIN_YELLOW > 99 || SUB_GREEN + SUB_YELLOW > 99) begin : g_bad_time
      $error("traffic_phase_ctrl: green+yellow must not exceed 99 s");
   end
   if (TICK_DIV < 2) begin : g_bad_div
      $error("traffic_phase_ctrl: TICK_DIV must be at least 2");
   end

   localparam logic [6:0] T_MG = 7'(MAIN_GREEN);
   localparam logic [6:0] T_MY = 7'(MAIN_YELLOW);
   localparam logic [6:0] T_SG = 7'(SUB_GREEN);
   localparam logic [6:0] T_SY = 7'(SUB_YELLOW);

   phase_e     state_q, state_d;
   logic [6:0] remain_q, remain_d;
   logic       flash_q, flash_d;
   logic       tick;
   logic       pre_clr;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (pre_clr),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      flash_d  = flash_q;
      pre_clr  = 1'b0;
      if (off) begin
         state_d  = PH_OFF;
         remain_d = T_MG;
         flash_d  = 1'b1;
         pre_clr  = 1'b1;
      end else if (night) begin
         if (state_q != PH_FLASH) begin
            state_d  = PH_FLASH;
            remain_d = T_MG;
            flash_d  = 1'b1;
            pre_clr  = 1'b1;
         end else if (tick) begin
            flash_d = ~flash_q;
         end
      end else if (state_q == PH_FLASH || state_q == PH_OFF) begin
         // Mode exit always restarts the cycle fresh; the old phase is lost.
         state_d  = PH_MG;
         remain_d = T_MG;
         pre_clr  = 1'b1;
      end else if (tick) begin
         if (remain_q > 7'd1) begin
            remain_d = remain_q - 7'd1;
         end else begin
            case (state_q)
               PH_MG:   begin state_d = PH_MY; remain_d = T_MY; end
               PH_MY:   begin state_d = PH_SG; remain_d = T_SG; end
               PH_SG:   begin state_d = PH_SY; remain_d = T_SY; end
               default: begin state_d = PH_MG; remain_d = T_MG; end
            endcase
         end
      end
   end

   // NOTE: the asynchronous reset covers every state flop so the cycle always
   // restarts from a known MG/full-count point, even mid-phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= PH_MG;
         remain_q <= T_MG;
         flash_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         flash_q  <= flash_d;
      end
   end

   always_comb begin
      main_rest_time = 7'd0;
      sub_rest_time  = 7'd0;
      dis            = 1'b0;
      non            = 1'b0;
      n1             = LAMP_NONE;
      n2             = LAMP_NONE;
      case (state_q)
         PH_MG: begin
            main_rest_time = remain_q;
            sub_rest_time  = remain_q + T_MY;
            n1             = LAMP_MAIN_G;
         end
         PH_MY: begin
            main_rest_time = remain_q;
            sub_rest_time  = remain_q;
            n1             = LAMP_MAIN_Y;
         end
         PH_SG: begin
            main_rest_time = remain_q + T_SY;
            sub_rest_time  = remain_q;
            n2             = LAMP_SUB_G;
         end
         PH_SY: begin
            main_rest_time = remain_q;
            sub_rest_time  = remain_q;
            n2             = LAMP_SUB_Y;
         end
         PH_FLASH: begin
            dis = 1'b1;
            if (flash_q) begin
               n1 = LAMP_MAIN_Y;
               n2 = LAMP_SUB_Y;
            end
         end
         default: non = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a short tick period; expected
// outputs come from hand-computed constants and a small timing model.
module tb_traffic_phase_ctrl;

   localparam int TD = 4;
   localparam int MG = 5;
   localparam int MY = 2;
   localparam int SG = 4;
   localparam int SY = 2;
   localparam int E_MG = MG * TD;
   localparam int E_MY = E_MG + MY * TD;
   localparam int E_SG = E_MY + SG * TD;
   localparam int E_SY = E_SG + SY * TD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       night = 1'b0;
   logic       off = 1'b0;
   logic [6:0] main_rest_time, sub_rest_time;
   logic       dis, non;
   logic [2:0] n1, n2;

   int n_checks = 0;
   int n_fail   = 0;

   traffic_phase_ctrl #(
      .TICK_DIV(TD), .MAIN_GREEN(MG), .MAIN_YELLOW(MY),
      .SUB_GREEN(SG), .SUB_YELLOW(SY)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .night(night), .off(off),
      .main_rest_time(main_rest_time), .sub_rest_time(sub_rest_time),
      .dis(dis), .non(non), .n1(n1), .n2(n2)
   );

   always #5 clk = ~clk;

   // {main, sub, n1, n2, dis, non}
   logic [21:0] obs;
   assign obs = {main_rest_time, sub_rest_time, n1, n2, dis, non};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [21:0] pack(input int m, input int s, input int a, input int b,
                                        input bit d, input bit z);
      return {7'(m), 7'(s), 3'(a), 3'(b), d, z};
   endfunction

   // Expected outputs k clocks after a fresh MG start with en held high.
   function automatic logic [21:0] exp_norm(input int k);
      int p, r;
      p = k % E_SY;
      if (p < E_MG)      begin r = MG - p / TD;          return pack(r, r + MY, 0, 5, 0, 0); end
      else if (p < E_MY) begin r = MY - (p - E_MG) / TD; return pack(r, r, 1, 5, 0, 0);      end
      else if (p < E_SG) begin r = SG - (p - E_MY) / TD; return pack(r + SY, r, 5, 2, 0, 0); end
      else               begin r = SY - (p - E_SG) / TD; return pack(r, r, 5, 3, 0, 0);      end
   endfunction

   localparam logic [21:0] FLASH_ON  = {7'd0, 7'd0, 3'd1, 3'd3, 1'b1, 1'b0};
   localparam logic [21:0] FLASH_OFF = {7'd0, 7'd0, 3'd5, 3'd5, 1'b1, 1'b0};
   localparam logic [21:0] OFF_OUT   = {7'd0, 7'd0, 3'd5, 3'd5, 1'b0, 1'b1};

   initial begin
      // Reset state
      #12;
      check("rst_main", main_rest_time, 7'd5);
      check("rst_sub", sub_rest_time, 7'd7);
      check("rst_lamps", {n1, n2}, {3'd0, 3'd5});
      check("rst_flags", {dis, non}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      // Two full cycles against the timing model; no zero countdown anywhere
      for (int k = 0; k < 2 * E_SY; k++) begin
         check($sformatf("cycle_k%0d", k), obs, exp_norm(k));
         check($sformatf("nz_main_k%0d", k), main_rest_time != 7'd0, 1);
         check($sformatf("nz_sub_k%0d", k), sub_rest_time != 7'd0, 1);
         step(1);
      end
      check("wrap_mg", obs, exp_norm(0));
      check("boundary_my", exp_norm(E_MG), pack(2, 2, 1, 5, 0, 0));

      // Freeze mid-MG with main=3 and prescaler at 1
      step(9);
      check("pre_freeze", main_rest_time, 7'd3);
      en = 1'b0;
      step(100);
      check("frozen", obs, exp_norm(9));
      en = 1'b1;
      step(2);
      check("resume_hold", main_rest_time, 7'd3);
      step(1);
      check("resume_tick", main_rest_time, 7'd2);
      step(3);
      check("resume_hold2", main_rest_time, 7'd2);
      step(1);
      check("resume_tick2", obs, exp_norm(16));

      // Night entered during SG
      step(14);
      check("in_sg", obs, pack(6, 4, 5, 2, 0, 0));
      night = 1'b1;
      step(1);
      check("flash_enter", obs, FLASH_ON);
      step(3);
      check("flash_hold", obs, FLASH_ON);
      step(1);
      check("flash_tog0", obs, FLASH_OFF);
      step(4);
      check("flash_tog1", obs, FLASH_ON);
      en = 1'b0;
      step(8);
      check("flash_frozen", obs, FLASH_ON);
      en = 1'b1;
      night = 1'b0;
      step(1);
      check("night_exit", obs, pack(5, 7, 0, 5, 0, 0));
      step(3);
      check("exit_pre_clr", main_rest_time, 7'd5);
      step(1);
      check("exit_first_tick", obs, exp_norm(4));

      // Off overrides night; en ignored while off
      off = 1'b1;
      night = 1'b1;
      step(1);
      check("off_enter", obs, OFF_OUT);
      en = 1'b0;
      step(5);
      check("off_hold", obs, OFF_OUT);
      en = 1'b1;
      off = 1'b0;
      step(1);
      check("off_to_flash", obs, FLASH_ON);
      night = 1'b0;
      step(1);
      check("flash_to_mg", obs, exp_norm(0));

      // Async reset between edges mid-SY
      step(E_SG + 2);
      check("in_sy", obs, pack(2, 2, 5, 3, 0, 0));
      #1 rst = 1'b1;
      #1;
      check("async_rst", obs, pack(5, 7, 0, 5, 0, 0));
      @(negedge clk);
      check("rst_held", obs, exp_norm(0));
      rst = 1'b0;
      step(E_MG);
      check("restart_my", obs, exp_norm(E_MG));
      step(E_MY - E_MG);
      check("restart_sg", obs, exp_norm(E_MY));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
